run_detect_scheduler: RTL
=========================

Name: run_detect_scheduler

Overview:
- Time-shares one bit-serial run-length detector among NCH requesters.
- Each requester submits W-bit words; the block grants requesters round-robin and shifts each granted word MSB-first through the shared detector, one bit per cycle.
- Per-channel detector context is saved and restored, so runs continue across words from the same channel.
- Sits between the stream sources and the sequence-detection consumer, replacing one detector instance per channel.

Parameters:
- NCH, 4, number of requesting channels (≥2).
- W, 8, word width in bits.
- RUN, 4, run length that flags a hit (≥2).
- CW, max(1,$clog2(NCH)), channel-index width (derived).
- HW, $clog2(W+1), hit-count width (derived).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NCH  per-channel word-valid.
- req_data  in  NCH*W  channel i word at bits [i*W +: W]; held stable while valid.
- req_ready  out  NCH  one-hot accept pulse.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_ch  out  CW  channel that produced the result.
- res_z_mask  out  W  per-bit hit flags; bit W-1 corresponds to the first bit processed.
- res_hits  out  HW  popcount of res_z_mask.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - req_ready=0, res_valid=0, res_ch=0, res_z_mask=0, res_hits=0.
  - State IDLE; last_grant=NCH-1.
  - For every channel: run_cnt=0, last_bit=0.
- Per-channel context: last_bit (1 bit) and run_cnt (0..RUN). run_cnt=0 means no history.
- Detector step for an incoming bit b:
  - If run_cnt≠0 and b==last_bit, then run_cnt=min(run_cnt+1,RUN); otherwise run_cnt=1.
  - last_bit=b.
  - z=(new run_cnt==RUN). A run longer than RUN flags every bit from the RUN-th bit onward.
- State machine:
  - IDLE: if any req_valid is set, grant the first valid channel searching last_grant+1, last_grant+2, … (wrap modulo NCH). In the same cycle: assert req_ready[g] combinationally for exactly one cycle, capture req_data[g] into the shift register, load g's context into the working context, set last_grant=g, clear the mask, then go to SHIFT. If no req_valid is set, stay in IDLE.
  - SHIFT: exactly W cycles, one detector step per cycle on shift-register MSB, shifting left. z enters the mask LSB and the mask shifts left. After the W-th step, write the working context back to channel g, register res_z_mask/res_hits/res_ch, assert res_valid, and go to DONE.
  - DONE: res_valid=1 and all result outputs are stable. On res_valid&&res_ready, deassert res_valid next cycle and go to IDLE.
- Timing:
  - Latency: accept in cycle 0 → res_valid high in cycle W+1.
  - Minimum word spacing with res_ready tied high: W+2 cycles.
- Boundary conditions:
  - req_ready is low in SHIFT and DONE; no grant occurs while a result is pending.
  - A single requester holding valid continuously is re-granted every W+2 cycles.
  - The context of non-granted channels is never modified.
  - Reset mid-SHIFT or mid-DONE: the block returns to IDLE the next cycle, the in-flight word is dropped with no result, and all contexts are cleared.
  - A req_valid that drops before grant is not accepted.
  - res_hits equals the popcount of res_z_mask at all times res_valid=1.

Test Plan:
- Reset, then ch0 sends 8'hF0 with RUN=4 and res_ready=1 → req_ready[0] pulses at cycle 0; res_valid at cycle 9 with res_ch=0, res_z_mask=8'h11, res_hits=2.
- Context carry-over on ch1: 8'h03 → mask 8'h1C, hits=3 (context after: last_bit=1, run_cnt=2). Then 8'hFF → mask 8'h7F, hits=7.
- After reset, all four req_valid are held high → grant order 0,1,2,3,0 with one grant every 10 cycles; each req_ready pulse lasts exactly one cycle.
- Interleave ch2 8'h00 with ch3 8'hAA → ch2 hits=5, mask 8'h1F; ch3 hits=0. A second ch2 8'h00 → mask 8'hFF, hits=8 (context isolation across ch3's word).
- res_ready held low for 5 cycles in DONE while ch1 is valid → res_* stable, req_ready stays 0, and ch1 is granted only in the cycle after the handshake plus IDLE.
- Reset asserted during the 3rd SHIFT cycle of a ch0 word → next cycle state is IDLE and res_valid=0; no result is produced. A subsequent ch0 8'h0F yields mask 8'h11, proving the context was cleared.

Source files
------------

// File: rtl/run_detect_scheduler.sv
// run_detect_scheduler
//   Shares one bit-serial run-length detector among NCH requesters. Words are
//   granted round-robin, shifted MSB-first through the detector (one bit per
//   cycle), and each channel's detector context (last bit, run count) is saved
//   and restored so runs carry across words from the same channel.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for any req_valid; grants one channel the same cycle
//   SHIFT | W detector steps on the granted word, MSB first
//   DONE  | result held on res_*; leaves on res_valid && res_ready
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid[NCH]        per-channel word valid
//   req_data[NCH*W]       channel i word at [i*W +: W], held while valid
//   req_ready[NCH]        one-hot, single-cycle accept pulse
//   res_valid/res_ready   result handshake
//   res_ch                channel that produced the result
//   res_z_mask            per-bit hit flags, bit W-1 = first bit processed
//   res_hits              popcount of res_z_mask
module run_detect_scheduler #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int RUN = 4,
  localparam int CW = (NCH > 2) ? $clog2(NCH) : 1,
  localparam int HW = $clog2(W + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NCH-1:0]     req_valid,
  input  logic [NCH*W-1:0]   req_data,
  output logic [NCH-1:0]     req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CW-1:0]      res_ch,
  output logic [W-1:0]       res_z_mask,
  output logic [HW-1:0]      res_hits
);

  localparam int RW = $clog2(RUN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   last_grant, grant, gnt_idx, lo_idx;
  logic            any_valid, found_hi, found_lo;
  logic [W-1:0]    sel_data, shreg, mask, mask_nxt;
  logic [HW-1:0]   bit_cnt, pop_nxt;
  logic            wrk_last, det_bit, det_z;
  logic [RW-1:0]   wrk_cnt, det_cnt;
  logic            ctx_last [NCH];
  logic [RW-1:0]   ctx_cnt  [NCH];

  // Round-robin: first valid channel above last_grant, otherwise the lowest
  // valid channel overall (which wraps back around to last_grant itself).
  always_comb begin
    any_valid = |req_valid;
    gnt_idx   = '0;
    lo_idx    = '0;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (req_valid[i] && (i > int'(last_grant)) && !found_hi) begin
        found_hi = 1'b1;
        gnt_idx  = CW'(i);
      end
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = CW'(i);
      end
    end
    if (!found_hi) gnt_idx = lo_idx;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == CW'(i)) sel_data = req_data[i*W +: W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid && !reset) req_ready[gnt_idx] = 1'b1;
  end

  // One detector step on the shift-register MSB. Count saturates at RUN so a
  // longer run keeps flagging every further bit.
  always_comb begin
    det_bit = shreg[W-1];
    if (wrk_cnt != '0 && det_bit == wrk_last)
      det_cnt = (wrk_cnt == RW'(RUN)) ? RW'(RUN) : wrk_cnt + RW'(1);
    else
      det_cnt = RW'(1);
    det_z    = (det_cnt == RW'(RUN));
    mask_nxt = {mask[W-2:0], det_z};
  end

  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < W; i++) pop_nxt = pop_nxt + HW'(mask_nxt[i]);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == '0) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= CW'(NCH - 1);
      grant      <= '0;
      shreg      <= '0;
      mask       <= '0;
      bit_cnt    <= '0;
      wrk_last   <= 1'b0;
      wrk_cnt    <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_z_mask <= '0;
      res_hits   <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx_last[i] <= 1'b0;
        ctx_cnt[i]  <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant      <= gnt_idx;
            last_grant <= gnt_idx;
            shreg      <= sel_data;
            wrk_last   <= ctx_last[gnt_idx];
            wrk_cnt    <= ctx_cnt[gnt_idx];
            mask       <= '0;
            bit_cnt    <= HW'(W - 1);
          end
        end
        SHIFT: begin
          shreg    <= {shreg[W-2:0], 1'b0};
          wrk_last <= det_bit;
          wrk_cnt  <= det_cnt;
          mask     <= mask_nxt;
          bit_cnt  <= bit_cnt - HW'(1);
          if (bit_cnt == '0) begin
            ctx_last[grant] <= det_bit;
            ctx_cnt[grant]  <= det_cnt;
            res_z_mask      <= mask_nxt;
            res_hits        <= pop_nxt;
            res_ch          <= grant;
            res_valid       <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
